// File: rtl/rr_mux_scheduler.sv
// Round-robin scheduler sharing one 8-to-1 select path among eight single-bit requesters.
// Grants are held for up to HOLD cycles, released early when the owner drops its request.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no active grant; s holds the index of the last grant
// ST_GRANT | gnt/s point at the owner; cnt counts down remaining cycles
module rr_mux_scheduler #(
   parameter int HOLD  = 4,
   parameter int CNT_W = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic [7:0] a,
   output logic [2:0] s,
   output logic       q,
   output logic [7:0] gnt,
   output logic       busy,
   output logic       done
);

   localparam int               HOLD_EFF = (HOLD < 1) ? 1 : HOLD;
   localparam logic [CNT_W-1:0] LOAD     = CNT_W'(HOLD_EFF - 1);

   typedef enum logic {
      ST_IDLE,
      ST_GRANT
   } state_t;

   state_t           state, state_nxt;
   logic [2:0]       s_nxt;
   logic [2:0]       last, last_nxt;
   logic [7:0]       gnt_nxt;
   logic             busy_nxt;
   logic             done_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             release_g;
   logic [2:0]       winner;

   // First requester after 'from', wrapping; 'from' itself is checked last.
   function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] from);
      logic [2:0] idx;
      pick = from;
      for (int k = 8; k >= 1; k--) begin
         idx = from + 3'(k);
         if (r[idx]) pick = idx;
      end
   endfunction

   assign release_g = (cnt == '0) || !req[s];
   assign winner    = (state == ST_GRANT) ? pick(req, s) : pick(req, last);

   always_comb begin
      state_nxt = state;
      s_nxt     = s;
      last_nxt  = last;
      gnt_nxt   = gnt;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (req != 8'h00) begin
               s_nxt     = winner;
               gnt_nxt   = 8'h01 << winner;
               busy_nxt  = 1'b1;
               cnt_nxt   = LOAD;
               state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (!release_g) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else begin
               last_nxt = s;
               done_nxt = 1'b1;
               if (req != 8'h00) begin
                  // back-to-back hand-over, search starts after the releasing owner
                  s_nxt   = winner;
                  gnt_nxt = 8'h01 << winner;
                  cnt_nxt = LOAD;
               end else begin
                  gnt_nxt   = 8'h00;
                  busy_nxt  = 1'b0;
                  cnt_nxt   = '0;
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         s     <= 3'd0;
         last  <= 3'd7;
         gnt   <= 8'h00;
         busy  <= 1'b0;
         done  <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         s     <= s_nxt;
         last  <= last_nxt;
         gnt   <= gnt_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
         cnt   <= cnt_nxt;
      end
   end

   assign q = busy ? a[s] : 1'b0;

endmodule

// File: tb/tb_rr_mux_scheduler.sv
// Bench for rr_mux_scheduler: three instances (HOLD=1,3,4) driven in parallel and
// compared every cycle against an owner/remaining-cycles reference model.
module tb_rr_mux_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic [7:0] a;

   logic [2:0] s_o    [3];
   logic       q_o    [3];
   logic [7:0] gnt_o  [3];
   logic       busy_o [3];
   logic       done_o [3];

   int total = 0;
   int bad   = 0;

   int hold_m  [3];
   int owner_m [3];
   int rem_m   [3];
   int last_m  [3];
   int s_m     [3];
   int done_m  [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int HV = (g == 0) ? 1 : (g == 1) ? 3 : 4;
      rr_mux_scheduler #(.HOLD(HV), .CNT_W(4)) u_dut (
         .clk  (clk),
         .rst  (rst),
         .req  (req),
         .a    (a),
         .s    (s_o[g]),
         .q    (q_o[g]),
         .gnt  (gnt_o[g]),
         .busy (busy_o[g]),
         .done (done_o[g])
      );
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int next_owner(input logic [7:0] r, input int from);
      for (int k = 1; k <= 8; k++)
         if (r[(from + k) % 8]) return (from + k) % 8;
      return -1;
   endfunction

   task automatic model_edge(input int i);
      if (rst) begin
         owner_m[i] = -1; rem_m[i] = 0; last_m[i] = 7; s_m[i] = 0; done_m[i] = 0;
      end else if (owner_m[i] < 0) begin
         done_m[i] = 0;
         if (req != 8'h00) begin
            owner_m[i] = next_owner(req, last_m[i]);
            rem_m[i]   = hold_m[i];
            s_m[i]     = owner_m[i];
         end
      end else if (rem_m[i] == 1 || !req[owner_m[i]]) begin
         last_m[i] = owner_m[i];
         done_m[i] = 1;
         if (req != 8'h00) begin
            owner_m[i] = next_owner(req, last_m[i]);
            rem_m[i]   = hold_m[i];
            s_m[i]     = owner_m[i];
         end else begin
            owner_m[i] = -1;
         end
      end else begin
         rem_m[i]--;
         done_m[i] = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_edge(i);
      #1;
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("gnt h%0d", hold_m[i]), 32'(gnt_o[i]),
                  (owner_m[i] >= 0) ? 32'(8'h01 << owner_m[i]) : 32'd0);
         check_eq($sformatf("s h%0d", hold_m[i]), 32'(s_o[i]), 32'(s_m[i]));
         check_eq($sformatf("busy h%0d", hold_m[i]), 32'(busy_o[i]), 32'(owner_m[i] >= 0));
         check_eq($sformatf("done h%0d", hold_m[i]), 32'(done_o[i]), 32'(done_m[i]));
         check_eq($sformatf("q h%0d", hold_m[i]), 32'(q_o[i]),
                  (owner_m[i] >= 0) ? 32'(a[owner_m[i]]) : 32'd0);
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run(2);
      rst = 1'b0;
   endtask

   initial begin
      hold_m[0] = 1; hold_m[1] = 3; hold_m[2] = 4;
      for (int i = 0; i < 3; i++) begin
         owner_m[i] = -1; rem_m[i] = 0; last_m[i] = 7; s_m[i] = 0; done_m[i] = 0;
      end
      rst = 1'b1;
      req = 8'h00;
      a   = 8'b0110_1111;
      do_reset();

      // sole requester is re-granted back-to-back
      req = 8'h01;
      run(10);

      // full rotation
      req = 8'hFF;
      run(18);

      // two requesters alternate
      do_reset();
      req = 8'h24;
      run(20);

      // early release to idle
      do_reset();
      req = 8'h08;
      run(2);
      req = 8'h00;
      run(4);

      // reset mid-grant, then re-request
      req = 8'h40;
      run(2);
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      run(3);

      // wrap-around from last=7
      do_reset();
      req = 8'h81;
      run(12);

      // unrelated requests arriving mid-grant
      req = 8'h10;
      run(2);
      req = 8'h1F;
      run(10);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         a = 8'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 3))
               0:       req = 8'h00;
               1:       req = 8'h01 << $urandom_range(0, 7);
               default: req = 8'($urandom);
            endcase
         end
         rst = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
